// File: rtl/regfile_scoreboard_if.sv
// Bus between the decode/writeback stages and the register file with its busy scoreboard.
// Decode and writeback take the master side; the register file takes the slave side.
interface regfile_scoreboard_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  ctrl_writeEnable;
    logic [ADDR_WIDTH-1:0] ctrl_writeReg;
    logic [DATA_WIDTH-1:0] data_writeReg;
    logic [ADDR_WIDTH-1:0] ctrl_readRegA;
    logic [ADDR_WIDTH-1:0] ctrl_readRegB;
    logic [DATA_WIDTH-1:0] data_readRegA;
    logic [DATA_WIDTH-1:0] data_readRegB;
    logic                  ctrl_issueEnable;
    logic [ADDR_WIDTH-1:0] ctrl_issueReg;
    logic                  ctrl_flush;
    logic                  data_busyA;
    logic                  data_busyB;
    logic [ADDR_WIDTH:0]   data_busyCount;

    modport master (
        output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
        output ctrl_readRegA, ctrl_readRegB,
        output ctrl_issueEnable, ctrl_issueReg, ctrl_flush,
        input  data_readRegA, data_readRegB, data_busyA, data_busyB, data_busyCount
    );

    modport slave (
        input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
        input  ctrl_readRegA, ctrl_readRegB,
        input  ctrl_issueEnable, ctrl_issueReg, ctrl_flush,
        output data_readRegA, data_readRegB, data_busyA, data_busyB, data_busyCount
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Parametrised register file (2 async read ports, 1 sync write port) with optional
// write-to-read bypass and a per-register busy scoreboard for hazard detection.
module regfile_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 1
) (
    input logic                 clock,
    input logic                 ctrl_reset_n,
    regfile_scoreboard_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      busy;
    logic [DEPTH-1:0]      busy_next;
    logic [CW-1:0]         busy_count;
    logic [CW-1:0]         count_next;
    logic                  write_ok;
    logic                  issue_ok;

    always_comb begin
        write_ok = bus.ctrl_writeEnable && !((ZERO_REG != 0) && (bus.ctrl_writeReg == '0));
        issue_ok = bus.ctrl_issueEnable && !((ZERO_REG != 0) && (bus.ctrl_issueReg == '0));
    end

    // Issue is applied after the write clear so a same-register issue wins; flush beats both.
    always_comb begin
        busy_next = busy;
        if (write_ok) busy_next[bus.ctrl_writeReg] = 1'b0;
        if (issue_ok) busy_next[bus.ctrl_issueReg] = 1'b1;
        if (bus.ctrl_flush) busy_next = '0;
        if (ZERO_REG != 0) busy_next[0] = 1'b0;
        count_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count_next = count_next + CW'(busy_next[i]);
        end
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (write_ok) begin
            regs[bus.ctrl_writeReg] <= bus.data_writeReg;
        end
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_next;
            busy_count <= count_next;
        end
    end

    // A write landing this cycle both forwards its data and retires the pending producer.
    always_comb begin
        bus.data_readRegA = regs[bus.ctrl_readRegA];
        bus.data_busyA    = busy[bus.ctrl_readRegA];
        if ((BYPASS != 0) && write_ok && (bus.ctrl_writeReg == bus.ctrl_readRegA)) begin
            bus.data_readRegA = bus.data_writeReg;
            bus.data_busyA    = 1'b0;
        end
        if ((ZERO_REG != 0) && (bus.ctrl_readRegA == '0)) begin
            bus.data_readRegA = '0;
            bus.data_busyA    = 1'b0;
        end
    end

    always_comb begin
        bus.data_readRegB = regs[bus.ctrl_readRegB];
        bus.data_busyB    = busy[bus.ctrl_readRegB];
        if ((BYPASS != 0) && write_ok && (bus.ctrl_writeReg == bus.ctrl_readRegB)) begin
            bus.data_readRegB = bus.data_writeReg;
            bus.data_busyB    = 1'b0;
        end
        if ((ZERO_REG != 0) && (bus.ctrl_readRegB == '0)) begin
            bus.data_readRegB = '0;
            bus.data_busyB    = 1'b0;
        end
    end

    assign bus.data_busyCount = busy_count;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed and randomised bench for regfile_scoreboard; a second instance without
// bypass shares the same stimulus to show the one-cycle-later visibility.
module tb_regfile_scoreboard;
    logic clock;
    logic ctrl_reset_n;
    int   checks = 0;
    int   passed = 0;

    regfile_scoreboard_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();
    regfile_scoreboard_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus_nb ();

    assign bus_nb.ctrl_writeEnable = bus.ctrl_writeEnable;
    assign bus_nb.ctrl_writeReg    = bus.ctrl_writeReg;
    assign bus_nb.data_writeReg    = bus.data_writeReg;
    assign bus_nb.ctrl_readRegA    = bus.ctrl_readRegA;
    assign bus_nb.ctrl_readRegB    = bus.ctrl_readRegB;
    assign bus_nb.ctrl_issueEnable = bus.ctrl_issueEnable;
    assign bus_nb.ctrl_issueReg    = bus.ctrl_issueReg;
    assign bus_nb.ctrl_flush       = bus.ctrl_flush;

    regfile_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1), .ZERO_REG(1)) u_dut (
        .clock        (clock),
        .ctrl_reset_n (ctrl_reset_n),
        .bus          (bus.slave)
    );

    regfile_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(0), .ZERO_REG(1)) u_dut_nb (
        .clock        (clock),
        .ctrl_reset_n (ctrl_reset_n),
        .bus          (bus_nb.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic idle();
        bus.ctrl_writeEnable = 1'b0;
        bus.ctrl_writeReg    = '0;
        bus.data_writeReg    = '0;
        bus.ctrl_issueEnable = 1'b0;
        bus.ctrl_issueReg    = '0;
        bus.ctrl_flush       = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        bus.ctrl_readRegA = 5'd5;
        bus.ctrl_readRegB = 5'd6;
        #1;
        checks++; if (bus.data_readRegA !== 32'h0) $display("[TB] FAIL reset_readA: got %h expected %h", bus.data_readRegA, 32'h0); else passed++;
        checks++; if (bus.data_busyB !== 1'b0) $display("[TB] FAIL reset_busyB: got %b expected %b", bus.data_busyB, 1'b0); else passed++;
        checks++; if (bus.data_busyCount !== 6'd0) $display("[TB] FAIL reset_count: got %0d expected %0d", bus.data_busyCount, 0); else passed++;
        bus.ctrl_writeEnable = 1'b1; bus.ctrl_writeReg = 5'd5; bus.data_writeReg = 32'hDEADBEEF;
        bus.ctrl_issueEnable = 1'b1; bus.ctrl_issueReg = 5'd6;
        tick();
        idle();
        #1;
        checks++; if (bus.data_readRegA !== 32'hDEADBEEF) $display("[TB] FAIL prereset_readA: got %h expected %h", bus.data_readRegA, 32'hDEADBEEF); else passed++;
        checks++; if (bus.data_busyB !== 1'b1) $display("[TB] FAIL prereset_busyB: got %b expected %b", bus.data_busyB, 1'b1); else passed++;
        checks++; if (bus.data_busyCount !== 6'd1) $display("[TB] FAIL prereset_count: got %0d expected %0d", bus.data_busyCount, 1); else passed++;
        #2 ctrl_reset_n = 1'b0;
        #1;
        checks++; if (bus.data_readRegA !== 32'h0) $display("[TB] FAIL midreset_readA: got %h expected %h", bus.data_readRegA, 32'h0); else passed++;
        checks++; if (bus.data_busyB !== 1'b0) $display("[TB] FAIL midreset_busyB: got %b expected %b", bus.data_busyB, 1'b0); else passed++;
        checks++; if (bus.data_busyCount !== 6'd0) $display("[TB] FAIL midreset_count: got %0d expected %0d", bus.data_busyCount, 0); else passed++;
        #2 ctrl_reset_n = 1'b1;
    endtask

    task automatic test_write_read_bypass();
        bus.ctrl_readRegA = 5'd7;
        bus.ctrl_readRegB = 5'd7;
        bus.ctrl_writeEnable = 1'b1; bus.ctrl_writeReg = 5'd7; bus.data_writeReg = 32'h12345678;
        #1;
        checks++; if (bus.data_readRegA !== 32'h12345678) $display("[TB] FAIL bypass_readA: got %h expected %h", bus.data_readRegA, 32'h12345678); else passed++;
        checks++; if (bus.data_readRegB !== 32'h12345678) $display("[TB] FAIL bypass_readB: got %h expected %h", bus.data_readRegB, 32'h12345678); else passed++;
        checks++; if (bus_nb.data_readRegA !== 32'h0) $display("[TB] FAIL nobypass_old_readA: got %h expected %h", bus_nb.data_readRegA, 32'h0); else passed++;
        tick();
        idle();
        #1;
        checks++; if (bus.data_readRegA !== 32'h12345678) $display("[TB] FAIL written_readA: got %h expected %h", bus.data_readRegA, 32'h12345678); else passed++;
        checks++; if (bus_nb.data_readRegA !== 32'h12345678) $display("[TB] FAIL nobypass_new_readA: got %h expected %h", bus_nb.data_readRegA, 32'h12345678); else passed++;
        checks++; if (bus_nb.data_readRegB !== 32'h12345678) $display("[TB] FAIL nobypass_new_readB: got %h expected %h", bus_nb.data_readRegB, 32'h12345678); else passed++;
    endtask

    task automatic test_zero_reg();
        bus.ctrl_readRegA = 5'd0;
        bus.ctrl_writeEnable = 1'b1; bus.ctrl_writeReg = 5'd0; bus.data_writeReg = 32'hFFFFFFFF;
        bus.ctrl_issueEnable = 1'b1; bus.ctrl_issueReg = 5'd0;
        #1;
        checks++; if (bus.data_readRegA !== 32'h0) $display("[TB] FAIL zero_bypass_readA: got %h expected %h", bus.data_readRegA, 32'h0); else passed++;
        tick();
        idle();
        #1;
        checks++; if (bus.data_readRegA !== 32'h0) $display("[TB] FAIL zero_readA: got %h expected %h", bus.data_readRegA, 32'h0); else passed++;
        checks++; if (bus.data_busyA !== 1'b0) $display("[TB] FAIL zero_busyA: got %b expected %b", bus.data_busyA, 1'b0); else passed++;
        checks++; if (bus.data_busyCount !== 6'd0) $display("[TB] FAIL zero_count: got %0d expected %0d", bus.data_busyCount, 0); else passed++;
    endtask

    task automatic test_scoreboard();
        bus.ctrl_readRegA = 5'd3;
        bus.ctrl_readRegB = 5'd4;
        bus.ctrl_issueEnable = 1'b1; bus.ctrl_issueReg = 5'd3;
        tick();
        #1;
        checks++; if (bus.data_busyCount !== 6'd1) $display("[TB] FAIL sb_count_issue3: got %0d expected %0d", bus.data_busyCount, 1); else passed++;
        checks++; if (bus.data_busyA !== 1'b1) $display("[TB] FAIL sb_busyA_3: got %b expected %b", bus.data_busyA, 1'b1); else passed++;
        bus.ctrl_issueReg = 5'd4;
        tick();
        idle();
        #1;
        checks++; if (bus.data_busyCount !== 6'd2) $display("[TB] FAIL sb_count_issue4: got %0d expected %0d", bus.data_busyCount, 2); else passed++;
        checks++; if (bus.data_busyB !== 1'b1) $display("[TB] FAIL sb_busyB_4: got %b expected %b", bus.data_busyB, 1'b1); else passed++;
        bus.ctrl_writeEnable = 1'b1; bus.ctrl_writeReg = 5'd3; bus.data_writeReg = 32'h00000333;
        #1;
        checks++; if (bus.data_busyA !== 1'b0) $display("[TB] FAIL sb_busyA_bypass_clear: got %b expected %b", bus.data_busyA, 1'b0); else passed++;
        checks++; if (bus_nb.data_busyA !== 1'b1) $display("[TB] FAIL sb_nobypass_busyA: got %b expected %b", bus_nb.data_busyA, 1'b1); else passed++;
        tick();
        idle();
        #1;
        checks++; if (bus.data_busyA !== 1'b0) $display("[TB] FAIL sb_busyA_cleared: got %b expected %b", bus.data_busyA, 1'b0); else passed++;
        checks++; if (bus.data_busyCount !== 6'd1) $display("[TB] FAIL sb_count_write3: got %0d expected %0d", bus.data_busyCount, 1); else passed++;
        bus.ctrl_writeEnable = 1'b1; bus.ctrl_writeReg = 5'd4; bus.data_writeReg = 32'h00000444;
        bus.ctrl_issueEnable = 1'b1; bus.ctrl_issueReg = 5'd4;
        tick();
        idle();
        #1;
        checks++; if (bus.data_busyB !== 1'b1) $display("[TB] FAIL sb_issue_wins_busy: got %b expected %b", bus.data_busyB, 1'b1); else passed++;
        checks++; if (bus.data_busyCount !== 6'd1) $display("[TB] FAIL sb_issue_wins_count: got %0d expected %0d", bus.data_busyCount, 1); else passed++;
        checks++; if (bus.data_readRegB !== 32'h00000444) $display("[TB] FAIL sb_issue_wins_data: got %h expected %h", bus.data_readRegB, 32'h00000444); else passed++;
    endtask

    task automatic test_flush();
        for (int r = 1; r < 32; r++) begin
            bus.ctrl_issueEnable = 1'b1;
            bus.ctrl_issueReg    = 5'(r);
            tick();
        end
        idle();
        #1;
        checks++; if (bus.data_busyCount !== 6'd31) $display("[TB] FAIL flush_full_count: got %0d expected %0d", bus.data_busyCount, 31); else passed++;
        bus.ctrl_issueEnable = 1'b1; bus.ctrl_issueReg = 5'd5;
        tick();
        idle();
        #1;
        checks++; if (bus.data_busyCount !== 6'd31) $display("[TB] FAIL flush_reissue_count: got %0d expected %0d", bus.data_busyCount, 31); else passed++;
        bus.ctrl_readRegA = 5'd9;
        bus.ctrl_readRegB = 5'd10;
        bus.ctrl_flush = 1'b1;
        bus.ctrl_issueEnable = 1'b1; bus.ctrl_issueReg = 5'd9;
        bus.ctrl_writeEnable = 1'b1; bus.ctrl_writeReg = 5'd10; bus.data_writeReg = 32'h0000A5A5;
        tick();
        idle();
        #1;
        checks++; if (bus.data_busyCount !== 6'd0) $display("[TB] FAIL flush_count: got %0d expected %0d", bus.data_busyCount, 0); else passed++;
        checks++; if (bus.data_busyA !== 1'b0) $display("[TB] FAIL flush_busyA_9: got %b expected %b", bus.data_busyA, 1'b0); else passed++;
        checks++; if (bus.data_readRegB !== 32'h0000A5A5) $display("[TB] FAIL flush_write_kept: got %h expected %h", bus.data_readRegB, 32'h0000A5A5); else passed++;
    endtask

    task automatic test_random();
        logic [31:0] m_regs [32];
        logic [31:0] m_busy;
        int          m_count;
        logic [31:0] exp_a, exp_b;
        logic        exp_ba, exp_bb;
        int          fails_before;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_busy  = '0;
        m_count = 0;
        ctrl_reset_n = 1'b0;
        #2 ctrl_reset_n = 1'b1;
        fails_before = checks - passed;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            bus.ctrl_writeEnable = ($urandom_range(0, 1) == 1);
            bus.ctrl_writeReg    = 5'($urandom_range(0, 31));
            bus.data_writeReg    = $urandom;
            bus.ctrl_issueEnable = ($urandom_range(0, 2) != 0);
            bus.ctrl_issueReg    = 5'($urandom_range(0, 31));
            bus.ctrl_flush       = ($urandom_range(0, 63) == 0);
            bus.ctrl_readRegA    = 5'($urandom_range(0, 31));
            bus.ctrl_readRegB    = ($urandom_range(0, 7) == 0) ? bus.ctrl_writeReg : 5'($urandom_range(0, 31));
            #1;
            exp_a  = (bus.ctrl_readRegA == 0) ? 32'h0 : m_regs[bus.ctrl_readRegA];
            exp_ba = (bus.ctrl_readRegA == 0) ? 1'b0 : m_busy[bus.ctrl_readRegA];
            exp_b  = (bus.ctrl_readRegB == 0) ? 32'h0 : m_regs[bus.ctrl_readRegB];
            exp_bb = (bus.ctrl_readRegB == 0) ? 1'b0 : m_busy[bus.ctrl_readRegB];
            if (bus.ctrl_writeEnable && bus.ctrl_writeReg != 0) begin
                if (bus.ctrl_writeReg == bus.ctrl_readRegA) begin exp_a = bus.data_writeReg; exp_ba = 1'b0; end
                if (bus.ctrl_writeReg == bus.ctrl_readRegB) begin exp_b = bus.data_writeReg; exp_bb = 1'b0; end
            end
            checks++; if (bus.data_readRegA !== exp_a) $display("[TB] FAIL rand_readA cyc %0d: got %h expected %h", cyc, bus.data_readRegA, exp_a); else passed++;
            checks++; if (bus.data_readRegB !== exp_b) $display("[TB] FAIL rand_readB cyc %0d: got %h expected %h", cyc, bus.data_readRegB, exp_b); else passed++;
            checks++; if (bus.data_busyA !== exp_ba) $display("[TB] FAIL rand_busyA cyc %0d: got %b expected %b", cyc, bus.data_busyA, exp_ba); else passed++;
            checks++; if (bus.data_busyB !== exp_bb) $display("[TB] FAIL rand_busyB cyc %0d: got %b expected %b", cyc, bus.data_busyB, exp_bb); else passed++;
            checks++; if (bus.data_busyCount !== 6'(m_count)) $display("[TB] FAIL rand_count cyc %0d: got %0d expected %0d", cyc, bus.data_busyCount, m_count); else passed++;
            if ((checks - passed) - fails_before > 20) begin
                $display("[TB] FAIL rand_abort: got %0d errors expected %0d", (checks - passed) - fails_before, 0);
                break;
            end
            @(posedge clock);
            if (bus.ctrl_writeEnable && bus.ctrl_writeReg != 0) m_regs[bus.ctrl_writeReg] = bus.data_writeReg;
            if (bus.ctrl_flush) begin
                m_busy  = '0;
                m_count = 0;
            end else begin
                if (bus.ctrl_issueEnable && bus.ctrl_issueReg != 0 && !m_busy[bus.ctrl_issueReg]) begin
                    m_busy[bus.ctrl_issueReg] = 1'b1;
                    m_count++;
                end
                if (bus.ctrl_writeEnable && bus.ctrl_writeReg != 0 && m_busy[bus.ctrl_writeReg]
                    && !(bus.ctrl_issueEnable && bus.ctrl_issueReg == bus.ctrl_writeReg)) begin
                    m_busy[bus.ctrl_writeReg] = 1'b0;
                    m_count--;
                end
            end
            #1;
        end
        idle();
    endtask

    initial begin
        ctrl_reset_n      = 1'b0;
        bus.ctrl_readRegA = '0;
        bus.ctrl_readRegB = '0;
        idle();
        #12 ctrl_reset_n = 1'b1;
        test_reset();
        test_write_read_bypass();
        test_zero_reg();
        test_scoreboard();
        test_flush();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
